// File: rtl/onehot_hist_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : onehot_hist_counter_pkg
// Description : Shared defaults, FSM state encoding and counter limit for the
//               one-hot histogram counter.
// Revision    : 1.0 - initial release
// ============================================================================
package onehot_hist_counter_pkg;

  localparam int N_BINS_DEF = 15;
  localparam int CNT_W_DEF  = 8;
  localparam int ADDR_W_DEF = 4;

  // Saturation value for counters of the default width
  localparam logic [CNT_W_DEF-1:0] CNT_MAX = {CNT_W_DEF{1'b1}};

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } fsm_state_t;

endpackage : onehot_hist_counter_pkg
`default_nettype wire

// File: rtl/onehot_hist_counter_classify.sv
`default_nettype none
// ============================================================================
// Module      : onehot_classify
// Description : Combinational classification of an event vector into
//               zero / one-hot / multi-hot, plus the binary index of the set
//               bit (meaningful only when the vector is one-hot).
// Revision    : 1.0 - initial release
// ============================================================================
module onehot_classify
  import onehot_hist_counter_pkg::*;
#(
  parameter int N_BINS = N_BINS_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [N_BINS-1:0] vec,
  output logic              is_zero,
  output logic              is_onehot,
  output logic              is_multi,
  output logic [ADDR_W-1:0] idx
);

  logic [N_BINS-1:0] low_cleared;

  // Clearing the lowest set bit leaves zero only for a single-bit vector
  always_comb begin
    low_cleared = vec & (vec - N_BINS'(1));
    is_zero     = ~|vec;
    is_onehot   = ~is_zero & ~|low_cleared;
    is_multi    = ~is_zero & |low_cleared;
  end

  // OR together the indices of all set bits; exact for a one-hot vector
  always_comb begin
    idx = '0;
    for (int i = 0; i < N_BINS; i++) begin
      if (vec[i]) idx = idx | ADDR_W'(i);
    end
  end

endmodule : onehot_classify
`default_nettype wire

// File: rtl/onehot_hist_counter.sv
`default_nettype none
// ============================================================================
// Module      : onehot_hist_counter
// Description : Per-bin saturating event histogram fed by a one-hot encoder,
//               with multi-hot error counting, a registered read port and a
//               sequential clear sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module onehot_hist_counter
  import onehot_hist_counter_pkg::*;
#(
  parameter int N_BINS = N_BINS_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_BINS-1:0] onehot,
  input  logic              clr,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  rd_data,
  output logic              rd_err,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              err_flag,
  output logic              busy
);

  localparam logic [CNT_W-1:0]  SAT_MAX  = {CNT_W{1'b1}};
  localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(N_BINS - 1);

  fsm_state_t        state, state_nxt;
  logic [N_BINS-1:0] ev_q;
  logic [ADDR_W-1:0] ptr;
  logic [CNT_W-1:0]  cnt [N_BINS];

  logic              is_zero, is_onehot, is_multi;
  logic [ADDR_W-1:0] hit_idx;
  logic              idle, sweep, start_clr, act;
  logic              addr_ok;
  logic [CNT_W-1:0]  rd_mux;

  onehot_classify #(
    .N_BINS (N_BINS),
    .ADDR_W (ADDR_W)
  ) u_classify (
    .vec       (ev_q),
    .is_zero   (is_zero),
    .is_onehot (is_onehot),
    .is_multi  (is_multi),
    .idx       (hit_idx)
  );

  // Input register: one cycle between encoder output and classification
  always_ff @(posedge clk) begin
    if (!rst) ev_q <= '0;
    else      ev_q <= onehot;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // FSM next state: sweep runs once over every bin, then returns to idle
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (clr) state_nxt = ST_CLEAR;
      ST_CLEAR: if (ptr == LAST_BIN) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs and qualifiers; all updates and reads are gated by idle
  always_comb begin
    idle      = (state == ST_IDLE);
    sweep     = (state == ST_CLEAR);
    busy      = sweep;
    start_clr = idle & clr;
    act       = idle & ~is_zero;
    addr_ok   = (rd_addr < ADDR_W'(N_BINS));
  end

  // Sweep pointer: restarts at bin 0 on each clear request
  always_ff @(posedge clk) begin
    if (!rst)           ptr <= '0;
    else if (start_clr) ptr <= '0;
    else if (sweep)     ptr <= ptr + ADDR_W'(1);
  end

  // Bin counters: cleared one per cycle by the sweep, otherwise saturating hits
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N_BINS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_BINS; i++) begin
        if (sweep && ptr == ADDR_W'(i)) begin
          cnt[i] <= '0;
        end else if (act && is_onehot && hit_idx == ADDR_W'(i) && cnt[i] != SAT_MAX) begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Error tracking: a clear request takes priority over a same-cycle error
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_cnt  <= '0;
      err_flag <= 1'b0;
    end else if (start_clr) begin
      err_cnt  <= '0;
      err_flag <= 1'b0;
    end else if (act && is_multi) begin
      err_flag <= 1'b1;
      if (err_cnt != SAT_MAX) err_cnt <= err_cnt + CNT_W'(1);
    end
  end

  // Read mux over the pre-edge counter values
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < N_BINS; i++) begin
      if (rd_addr == ADDR_W'(i)) rd_mux = cnt[i];
    end
  end

  // Read port: strobes pulse per accepted request, data holds between reads
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= idle & rd_req;
      rd_err   <= idle & rd_req & ~addr_ok;
      if (idle && rd_req) rd_data <= addr_ok ? rd_mux : '0;
    end
  end

endmodule : onehot_hist_counter
`default_nettype wire
